// File: rtl/fp16_norm_round_pkg.sv
// Shared definitions for the FP16 normalise/round/pack pipeline.
// Optional feature macro: FP16_SUBNORMAL_EN (gradual underflow instead of flush-to-zero).
package fp16_norm_round_pkg;

   localparam int EXP_IN_W  = 7;
   localparam int EXP_W     = 5;
   localparam int MAN_W     = 10;
   localparam int BIAS      = 15;
   localparam int EXP_MAX   = 2 * BIAS + 1;
   localparam int INT_EXP_W = EXP_IN_W + 2;
   localparam int RAW_W     = 16;
   localparam int NRM_W     = RAW_W - 1;

   localparam int FLAG_OVF = 2;
   localparam int FLAG_UNF = 1;
   localparam int FLAG_INX = 0;

   localparam logic [EXP_W+MAN_W-1:0] FP16_INF_MAG  = 15'h7C00;
   localparam logic [EXP_W+MAN_W-1:0] FP16_ZERO_MAG = 15'h0000;

endpackage

// File: rtl/fp16_rne_pack.sv
// Round-to-nearest-even, overflow/underflow detection and IEEE half packing.
// Optional feature macro: FP16_SUBNORMAL_EN (tiny values kept as subnormals, else flushed).
module fp16_rne_pack
   import fp16_norm_round_pkg::*;
(
   input  logic                 sign,
   input  logic [INT_EXP_W-1:0] exponent,
   input  logic [NRM_W-1:0]     mantissa,
   input  logic                 sticky,
   input  logic                 tiny,
   input  logic                 zero,
   output logic [15:0]          data,
   output logic [2:0]           flags
);

   localparam int XW = INT_EXP_W + 1;

   logic            guard;
   logic            rs;
   logic            up;
   logic            inexact;
   logic [MAN_W+1:0] sum;
   logic [XW-1:0]   base;
   logic [XW-1:0]   exp_fin;

   // The implicit bit rides along in the sum, so sum[11:10] is 1 for a plain normal,
   // 2 after a mantissa carry, and 0/1 for a subnormal that stays/becomes normal.
   always_comb begin
      guard   = mantissa[3];
      rs      = (|mantissa[2:0]) | sticky;
      up      = guard & (rs | mantissa[4]);
      inexact = guard | rs;
      sum     = {1'b0, mantissa[NRM_W-1:4]} + {{(MAN_W+1){1'b0}}, up};
      base    = tiny ? '0 : ({exponent[INT_EXP_W-1], exponent} - XW'(1));
      exp_fin = base + {{(XW-2){1'b0}}, sum[MAN_W+1:MAN_W]};
      data    = {sign, exp_fin[EXP_W-1:0], sum[MAN_W-1:0]};
      flags   = 3'b000;
      if (zero) begin
         data = {sign, FP16_ZERO_MAG};
      end else if (tiny) begin
`ifdef FP16_SUBNORMAL_EN
         flags[FLAG_UNF] = inexact;
         flags[FLAG_INX] = inexact;
`else
         data            = {sign, FP16_ZERO_MAG};
         flags[FLAG_UNF] = 1'b1;
         flags[FLAG_INX] = 1'b1;
`endif
      end else if ($signed(exp_fin) >= $signed(XW'(EXP_MAX))) begin
         data            = {sign, FP16_INF_MAG};
         flags[FLAG_OVF] = 1'b1;
         flags[FLAG_INX] = 1'b1;
      end else begin
         flags[FLAG_INX] = inexact;
      end
   end

endmodule

// File: rtl/lzc16.sv
// 16-bit leading-zero counter; returns 16 for an all-zero input.
module lzc16 (
   input  logic [15:0] data,
   output logic [4:0]  count
);

   // Scan upward so the highest set bit is the last one to set the count.
   always_comb begin
      count = 5'd16;
      for (int i = 0; i < 16; i++) begin
         if (data[i]) count = 5'(15 - i);
      end
   end

endmodule

// File: rtl/fp16_norm_round.sv
// FP16 normalise/round/pack: 3-stage valid/ready pipeline after the adder raw-sum stage.
// S1 leading-zero count, S2 normalise shift and exponent adjust, S3 round and pack.
// Optional feature macro: FP16_SUBNORMAL_EN (denormalising right shift for tiny results).
module fp16_norm_round
   import fp16_norm_round_pkg::*;
(
   input  logic                clk,
   input  logic                resetn,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_sign,
   input  logic [EXP_IN_W-1:0] in_exp,
   input  logic [RAW_W-1:0]    in_man,
   input  logic                in_sticky,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [15:0]         out_data,
   output logic [2:0]          out_flags
);

   logic pipe_en;

   logic [4:0]          lz_raw;
   logic                s1_valid;
   logic                s1_sign;
   logic [EXP_IN_W-1:0] s1_exp;
   logic [RAW_W-1:0]    s1_man;
   logic                s1_sticky;
   logic [3:0]          s1_lz;
   logic                s1_zero;
   logic                s1_carry;

   logic [INT_EXP_W-1:0] s1_exp_ext;
   logic [3:0]           lshift;
   logic [NRM_W-1:0]     norm_man;
   logic [INT_EXP_W-1:0] norm_exp;
   logic                 norm_sticky;
   logic                 norm_tiny;
   logic [NRM_W-1:0]     stage_man;
   logic                 stage_sticky;
`ifdef FP16_SUBNORMAL_EN
   logic [INT_EXP_W-1:0] den_dist;
   logic [3:0]           den_sh;
   logic [NRM_W-1:0]     den_mask;
`endif

   logic                 s2_valid;
   logic                 s2_sign;
   logic [INT_EXP_W-1:0] s2_exp;
   logic [NRM_W-1:0]     s2_man;
   logic                 s2_sticky;
   logic                 s2_tiny;
   logic                 s2_zero;

   logic [15:0] pack_data;
   logic [2:0]  pack_flags;

   assign pipe_en  = ~out_valid | out_ready;
   assign in_ready = pipe_en;

   lzc16 u_lzc (
      .data  (in_man),
      .count (lz_raw)
   );

   // S1: capture the beat with its leading-zero count; a count of 16 means zero mantissa.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         s1_valid <= 1'b0;
      end else if (pipe_en) begin
         s1_valid  <= in_valid;
         s1_sign   <= in_sign;
         s1_exp    <= in_exp;
         s1_man    <= in_man;
         s1_sticky <= in_sticky;
         s1_lz     <= lz_raw[3:0];
         s1_zero   <= lz_raw[4];
         s1_carry  <= in_man[RAW_W-1];
      end
   end

   // S2: bring the leading one to bit 14, adjust the exponent, then denormalise tiny values.
   always_comb begin
      s1_exp_ext  = {{(INT_EXP_W-EXP_IN_W){s1_exp[EXP_IN_W-1]}}, s1_exp};
      lshift      = s1_lz - 4'd1;
      norm_man    = s1_carry ? s1_man[RAW_W-1:1] : (s1_man[NRM_W-1:0] << lshift);
      norm_exp    = s1_carry ? (s1_exp_ext + INT_EXP_W'(1))
                             : (s1_exp_ext - {{(INT_EXP_W-4){1'b0}}, lshift});
      norm_sticky = s1_sticky | (s1_carry & s1_man[0]);
      norm_tiny   = ($signed(norm_exp) <= 0);
`ifdef FP16_SUBNORMAL_EN
      den_dist = INT_EXP_W'(1) - norm_exp;
      if (!norm_tiny) begin
         den_sh = 4'd0;
      end else if ($signed(den_dist) > $signed(INT_EXP_W'(12))) begin
         den_sh = 4'd12;
      end else begin
         den_sh = den_dist[3:0];
      end
      den_mask     = (NRM_W'(1) << den_sh) - NRM_W'(1);
      stage_man    = norm_man >> den_sh;
      stage_sticky = norm_sticky | (|(norm_man & den_mask));
`else
      stage_man    = norm_man;
      stage_sticky = norm_sticky;
`endif
   end

   // S2 register: hold the normalised operand for rounding.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         s2_valid <= 1'b0;
      end else if (pipe_en) begin
         s2_valid  <= s1_valid;
         s2_sign   <= s1_sign;
         s2_exp    <= norm_exp;
         s2_man    <= stage_man;
         s2_sticky <= stage_sticky;
         s2_tiny   <= norm_tiny;
         s2_zero   <= s1_zero;
      end
   end

   fp16_rne_pack u_pack (
      .sign     (s2_sign),
      .exponent (s2_exp),
      .mantissa (s2_man),
      .sticky   (s2_sticky),
      .tiny     (s2_tiny),
      .zero     (s2_zero),
      .data     (pack_data),
      .flags    (pack_flags)
   );

   // S3 output register: only moves when downstream can take it, so a stalled result holds.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         out_valid <= 1'b0;
         out_data  <= 16'h0000;
         out_flags <= 3'b000;
      end else if (pipe_en) begin
         out_valid <= s2_valid;
         out_data  <= pack_data;
         out_flags <= pack_flags;
      end
   end

endmodule

// File: tb/tb_fp16_norm_round.sv
// Directed bench for fp16_norm_round; expected values hand-computed.
// Honours FP16_SUBNORMAL_EN for the tiny-result expectations.
module tb_fp16_norm_round;

   logic        clk = 1'b0;
   logic        resetn;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [6:0]  in_exp;
   logic [15:0] in_man;
   logic        in_sticky;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [2:0]  out_flags;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   fp16_norm_round dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .in_exp    (in_exp),
      .in_man    (in_man),
      .in_sticky (in_sticky),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_flags (out_flags)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("[TB] FAIL %s: got %h, expected %h", tag, obs, expv);
      end
   endtask

   task automatic apply_stimulus(input logic sgn, input logic [6:0] e, input logic [15:0] m,
                                 input logic st);
      in_valid  = 1'b1;
      in_sign   = sgn;
      in_exp    = e;
      in_man    = m;
      in_sticky = st;
   endtask

   task automatic run_beat(input string tag, input logic sgn, input logic [6:0] e,
                           input logic [15:0] m, input logic st,
                           input logic [15:0] exp_data, input logic [2:0] exp_flags);
      out_ready = 1'b1;
      apply_stimulus(sgn, e, m, st);
      check_output({tag, " in_ready"}, {15'b0, in_ready}, 16'd1);
      tick();
      in_valid = 1'b0;
      tick();
      check_output({tag, " early"}, {15'b0, out_valid}, 16'd0);
      tick();
      check_output({tag, " valid"}, {15'b0, out_valid}, 16'd1);
      check_output({tag, " data"}, out_data, exp_data);
      check_output({tag, " flags"}, {13'b0, out_flags}, {13'b0, exp_flags});
      tick();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      resetn    = 1'b0;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_exp    = 7'd0;
      in_man    = 16'h0000;
      in_sticky = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      tick();
      check_output("reset out_valid", {15'b0, out_valid}, 16'd0);
      check_output("reset out_data", out_data, 16'h0000);
      check_output("reset out_flags", {13'b0, out_flags}, 16'd0);
      check_output("reset in_ready", {15'b0, in_ready}, 16'd1);
      resetn = 1'b1;
      tick();

      run_beat("one",      1'b0, 7'd15, 16'h4000, 1'b0, 16'h3C00, 3'b000);
      run_beat("carry",    1'b0, 7'd15, 16'h8000, 1'b0, 16'h4000, 3'b000);
      run_beat("cancel",   1'b0, 7'd15, 16'h0010, 1'b0, 16'h1400, 3'b000);
      run_beat("rne_up",   1'b0, 7'd15, 16'h4018, 1'b0, 16'h3C02, 3'b001);
      run_beat("rne_tie0", 1'b0, 7'd15, 16'h4008, 1'b0, 16'h3C00, 3'b001);
      run_beat("rne_gt",   1'b0, 7'd15, 16'h400C, 1'b0, 16'h3C01, 3'b001);
      run_beat("sticky",   1'b0, 7'd15, 16'h4008, 1'b1, 16'h3C01, 3'b001);
      run_beat("ovf_pos",  1'b0, 7'd30, 16'h7FF8, 1'b0, 16'h7C00, 3'b101);
      run_beat("ovf_neg",  1'b1, 7'd30, 16'h7FF8, 1'b0, 16'hFC00, 3'b101);
      run_beat("neg_half", 1'b1, 7'd14, 16'h4000, 1'b0, 16'hB800, 3'b000);
`ifdef FP16_SUBNORMAL_EN
      run_beat("tiny",     1'b0, 7'd0,  16'h4000, 1'b0, 16'h0200, 3'b000);
`else
      run_beat("tiny",     1'b0, 7'd0,  16'h4000, 1'b0, 16'h0000, 3'b011);
`endif
      run_beat("exp_min",  1'b0, 7'h40, 16'h4000, 1'b0, 16'h0000, 3'b011);
      run_beat("zero_neg", 1'b1, 7'd20, 16'h0000, 1'b0, 16'h8000, 3'b000);

      // back-to-back beats into a stalled sink
      out_ready = 1'b0;
      apply_stimulus(1'b0, 7'd15, 16'h4000, 1'b0);
      tick();
      apply_stimulus(1'b0, 7'd15, 16'h8000, 1'b0);
      tick();
      apply_stimulus(1'b0, 7'd15, 16'h0010, 1'b0);
      tick();
      apply_stimulus(1'b0, 7'd15, 16'h4018, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check_output("stall valid", {15'b0, out_valid}, 16'd1);
         check_output("stall data", out_data, 16'h3C00);
         check_output("stall in_ready", {15'b0, in_ready}, 16'd0);
         tick();
      end
      out_ready = 1'b1;
      check_output("drain A", out_data, 16'h3C00);
      tick();
      in_valid = 1'b0;
      check_output("drain B", out_data, 16'h4000);
      tick();
      check_output("drain C", out_data, 16'h1400);
      tick();
      check_output("drain D", out_data, 16'h3C02);
      check_output("drain D flags", {13'b0, out_flags}, 16'd1);
      tick();
      check_output("drain empty", {15'b0, out_valid}, 16'd0);

      // reset while the pipe is full
      apply_stimulus(1'b0, 7'd15, 16'h4000, 1'b0);
      tick();
      apply_stimulus(1'b0, 7'd15, 16'h8000, 1'b0);
      tick();
      apply_stimulus(1'b0, 7'd15, 16'h0010, 1'b0);
      tick();
      check_output("pre-reset valid", {15'b0, out_valid}, 16'd1);
      check_output("pre-reset data", out_data, 16'h3C00);
      resetn   = 1'b0;
      in_valid = 1'b0;
      tick();
      check_output("mid reset valid", {15'b0, out_valid}, 16'd0);
      check_output("mid reset data", out_data, 16'h0000);
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_output("post reset stale", {15'b0, out_valid}, 16'd0);
      end

      run_beat("after reset", 1'b0, 7'd15, 16'h4000, 1'b0, 16'h3C00, 3'b000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
